// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: LANES payload lanes, each with a valid bit.
// On each edge it does one of flush, bubble, load or hold, picked from the
// shared stall vector. Two saturating counters record hold and bubble cycles.
module pipe_stage_reg #(
    parameter int                DATA_W  = 32,
    parameter int                LANES   = 1,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                STALL_W = 6,
    parameter int                STAGE   = 2,
    parameter int                CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        kill,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        in_valid,
    input  logic                    cnt_clr,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_valid,
    output logic [CNT_W-1:0]        hold_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam logic [LANES*DATA_W-1:0] NOP_ALL = {LANES{NOP_VAL}};
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

    logic                    s_up;
    logic                    s_dn;
    logic                    do_bubble;
    logic                    do_hold;
    logic [LANES-1:0]        load_valid;
    logic [LANES*DATA_W-1:0] load_data;

    assign s_up = stall[STAGE];
    assign s_dn = stall[STAGE+1];

    // A flush edge is never counted, even when the stall bits ask for hold/bubble.
    assign do_bubble = ~flush & s_up & ~s_dn;
    assign do_hold   = ~flush & s_up &  s_dn;

    // Per-lane load value: killed or invalid lanes carry NOP_VAL, never stale data.
    always_comb begin
        load_valid = '0;
        load_data  = NOP_ALL;
        for (int i = 0; i < LANES; i++) begin
            load_valid[i] = in_valid[i] & ~kill[i];
            if (load_valid[i]) begin
                load_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Payload/valid register: flush, then bubble, then load; otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= NOP_ALL;
            out_valid <= '0;
        end else if (flush || do_bubble) begin
            out_data  <= NOP_ALL;
            out_valid <= '0;
        end else if (!s_up) begin
            out_data  <= load_data;
            out_valid <= load_valid;
        end
    end

    // Hold counter: saturates at all-ones; clear beats a same-edge increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (cnt_clr) begin
            hold_cnt <= '0;
        end else if (do_hold && hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Bubble counter: saturates at all-ones; clear beats a same-edge increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (do_bubble && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (2 lanes x 8 bits, 4-bit counters): directed table,
// hand-written corner sequences and random stimulus against a behavioural model.
module tb_pipe_stage_reg;

    localparam int          DATA_W  = 8;
    localparam int          LANES   = 2;
    localparam logic [7:0]  NOP_VAL = 8'h00;
    localparam int          STALL_W = 6;
    localparam int          STAGE   = 2;
    localparam int          CNT_W   = 4;
    localparam int          CMAX    = 15;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic [LANES-1:0]        kill;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        in_valid;
    logic                    cnt_clr;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_valid;
    logic [CNT_W-1:0]        hold_cnt;
    logic [CNT_W-1:0]        bubble_cnt;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .LANES(LANES), .NOP_VAL(NOP_VAL),
        .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .kill(kill),
        .in_data(in_data), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .out_data(out_data), .out_valid(out_valid),
        .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: what the downstream stage should see.
    logic [7:0] m_data [LANES];
    logic       m_valid[LANES];
    int         m_hold;
    int         m_bub;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [1:0]  kill;
        logic [15:0] din;
        logic [1:0]  vin;
        logic        clr;
        logic [15:0] edata;
        logic [1:0]  evalid;
        logic [3:0]  ehold;
        logic [3:0]  ebub;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_data[i]  = NOP_VAL;
            m_valid[i] = 1'b0;
        end
        m_hold = 0;
        m_bub  = 0;
    endtask

    task automatic model_step();
        bit up, dn;
        up = stall[STAGE];
        dn = stall[STAGE+1];
        if (flush || (up && !dn)) begin
            for (int i = 0; i < LANES; i++) begin
                m_data[i]  = NOP_VAL;
                m_valid[i] = 1'b0;
            end
        end else if (!up) begin
            for (int i = 0; i < LANES; i++) begin
                m_valid[i] = in_valid[i] && !kill[i];
                m_data[i]  = m_valid[i] ? in_data[i*DATA_W +: DATA_W] : NOP_VAL;
            end
        end
        if (!flush && up && !dn) m_bub  = (m_bub  < CMAX) ? m_bub  + 1 : CMAX;
        if (!flush && up &&  dn) m_hold = (m_hold < CMAX) ? m_hold + 1 : CMAX;
        if (cnt_clr) begin
            m_hold = 0;
            m_bub  = 0;
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, " data"},   out_data,   {m_data[1], m_data[0]});
        chk({nm, " valid"},  out_valid,  {m_valid[1], m_valid[0]});
        chk({nm, " hold"},   hold_cnt,   m_hold);
        chk({nm, " bubble"}, bubble_cnt, m_bub);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic set_in(input logic [5:0] s, input logic f, input logic [1:0] k,
                          input logic [15:0] d, input logic [1:0] v, input logic c);
        stall = s; flush = f; kill = k; in_data = d; in_valid = v; cnt_clr = c;
    endtask

    initial begin
        //            stall      fl  kill   din       vin    clr  edata     eval  eh    eb
        vt[0]  = '{6'b000000, 1'b0, 2'b00, 16'hB2A1, 2'b11, 1'b0, 16'hB2A1, 2'b11, 4'd0, 4'd0};
        vt[1]  = '{6'b000111, 1'b0, 2'b00, 16'h1111, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd0, 4'd1};
        vt[2]  = '{6'b001111, 1'b0, 2'b00, 16'h2222, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd1, 4'd1};
        vt[3]  = '{6'b001111, 1'b0, 2'b00, 16'h3333, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd2, 4'd1};
        vt[4]  = '{6'b001111, 1'b0, 2'b00, 16'h4444, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd3, 4'd1};
        vt[5]  = '{6'b000000, 1'b0, 2'b00, 16'h1234, 2'b11, 1'b0, 16'h1234, 2'b11, 4'd3, 4'd1};
        vt[6]  = '{6'b001111, 1'b0, 2'b00, 16'h5678, 2'b11, 1'b0, 16'h1234, 2'b11, 4'd4, 4'd1};
        vt[7]  = '{6'b001111, 1'b0, 2'b01, 16'h9ABC, 2'b01, 1'b0, 16'h1234, 2'b11, 4'd5, 4'd1};
        vt[8]  = '{6'b000000, 1'b0, 2'b10, 16'hCCDD, 2'b11, 1'b0, 16'h00DD, 2'b01, 4'd5, 4'd1};
        vt[9]  = '{6'b000000, 1'b0, 2'b00, 16'hEE55, 2'b01, 1'b0, 16'h0055, 2'b01, 4'd5, 4'd1};
        vt[10] = '{6'b001111, 1'b1, 2'b00, 16'hFFFF, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd5, 4'd1};
        vt[11] = '{6'b000000, 1'b0, 2'b00, 16'h7766, 2'b11, 1'b0, 16'h7766, 2'b11, 4'd5, 4'd1};
        vt[12] = '{6'b000000, 1'b1, 2'b00, 16'h4433, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd5, 4'd1};
        vt[13] = '{6'b000000, 1'b0, 2'b00, 16'h2211, 2'b10, 1'b0, 16'h2200, 2'b10, 4'd5, 4'd1};
        vt[14] = '{6'b000111, 1'b1, 2'b00, 16'h9999, 2'b11, 1'b0, 16'h0000, 2'b00, 4'd5, 4'd1};
        vt[15] = '{6'b110011, 1'b0, 2'b00, 16'hABCD, 2'b11, 1'b0, 16'hABCD, 2'b11, 4'd5, 4'd1};
        vt[16] = '{6'b001000, 1'b0, 2'b00, 16'h1357, 2'b11, 1'b0, 16'h1357, 2'b11, 4'd5, 4'd1};
        vt[17] = '{6'b000111, 1'b0, 2'b00, 16'h2468, 2'b11, 1'b1, 16'h0000, 2'b00, 4'd0, 4'd0};
    end

    initial begin
        rst = 1'b0;
        set_in(6'b0, 1'b0, 2'b00, 16'h0, 2'b00, 1'b0);
        model_reset();
        #12 rst = 1'b1;

        // Load something non-zero, then assert reset between edges.
        set_in(6'b000000, 1'b0, 2'b00, 16'h5A3C, 2'b11, 1'b0);
        tick();
        chk_model("preload");
        #3 rst = 1'b0;
        #1;
        chk("async reset data",   out_data,   16'h0000);
        chk("async reset valid",  out_valid,  2'b00);
        chk("async reset hold",   hold_cnt,   4'd0);
        chk("async reset bubble", bubble_cnt, 4'd0);
        model_reset();
        #2 rst = 1'b1;

        // Directed table.
        for (int r = 0; r < 18; r++) begin
            set_in(vt[r].stall, vt[r].flush, vt[r].kill, vt[r].din, vt[r].vin, vt[r].clr);
            tick();
            chk($sformatf("row%0d data", r),   out_data,   vt[r].edata);
            chk($sformatf("row%0d valid", r),  out_valid,  vt[r].evalid);
            chk($sformatf("row%0d hold", r),   hold_cnt,   vt[r].ehold);
            chk($sformatf("row%0d bubble", r), bubble_cnt, vt[r].ebub);
        end

        // Hold counter saturation, then clear while still holding.
        set_in(6'b001111, 1'b0, 2'b00, 16'h0, 2'b11, 1'b0);
        for (int i = 0; i < 20; i++) begin
            in_data = 16'($urandom);
            tick();
            chk_model($sformatf("sat%0d", i));
        end
        chk("saturated hold", hold_cnt, 4'hF);
        cnt_clr = 1'b1;
        tick();
        chk("clear hold", hold_cnt, 4'd0);
        cnt_clr = 1'b0;
        tick();
        chk("after clear hold", hold_cnt, 4'd1);

        // Reset pulse between edges during hold, then a normal load.
        set_in(6'b000000, 1'b0, 2'b00, 16'h4321, 2'b11, 1'b0);
        tick();
        set_in(6'b001111, 1'b0, 2'b00, 16'hDEAD, 2'b11, 1'b0);
        tick();
        chk_model("prehold");
        #2 rst = 1'b0;
        #1;
        chk("mid-hold reset data",   out_data,   16'h0000);
        chk("mid-hold reset valid",  out_valid,  2'b00);
        chk("mid-hold reset hold",   hold_cnt,   4'd0);
        chk("mid-hold reset bubble", bubble_cnt, 4'd0);
        model_reset();
        #2 rst = 1'b1;
        set_in(6'b000000, 1'b0, 2'b00, 16'h9E8D, 2'b11, 1'b0);
        tick();
        chk("post-reset load data",  out_data,  16'h9E8D);
        chk("post-reset load valid", out_valid, 2'b11);

        // Random traffic against the model (s_dn only when s_up).
        for (int i = 0; i < 400; i++) begin
            logic [5:0] s;
            int sel;
            s   = 6'($urandom);
            sel = $urandom_range(0, 2);
            s[STAGE]   = (sel != 0);
            s[STAGE+1] = (sel == 2);
            set_in(s, ($urandom_range(0, 9) == 0), 2'($urandom), 16'($urandom),
                   2'($urandom), ($urandom_range(0, 19) == 0));
            tick();
            chk_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
